// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM states and address constants.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running performance counters for the fetch controller (stall cycles, accepted redirects).
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall_evt,
  input  logic        i_flush_evt,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (i_stall_evt) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (i_flush_evt) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage sequencer over a req/ack instruction memory, with redirect flush and stall hold.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_drop_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_instr_valid;
  logic         w_load;
  logic         w_abandon;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    w_load      = 1'b0;
    w_abandon   = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (redirect) begin
          w_state_nxt = mem_ack ? FETCH : DROP;
          w_abandon   = ~mem_ack;
        end else if (mem_ack) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) w_state_nxt = FETCH;
      end
      DROP: begin
        mem_req = 1'b1;
        if (!redirect && mem_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  // While draining an abandoned request the memory still sees the old address,
  // even though fetch_pc already holds the redirect target.
  assign mem_addr = (r_state == DROP) ? r_drop_addr : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_drop_addr   <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_abandon) r_drop_addr <= r_fetch_pc;
      if (redirect) begin
        r_fetch_pc    <= redirect_addr;
        r_instr_valid <= 1'b0;
      end else if (w_load) begin
        r_instr       <= mem_rdata;
        r_instr_pc    <= r_fetch_pc;
        r_instr_valid <= 1'b1;
        r_fetch_pc    <= r_fetch_pc + PC_INCR;
      end else if (r_state == HOLD && !stall) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign pc_plus_4   = r_instr_pc + PC_INCR;

`ifdef FETCH_PERF_CNT_EN
  logic w_stall_evt;
  assign w_stall_evt = (r_state == HOLD) && stall;

  fetch_perf_cnt u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_stall_evt    (w_stall_evt),
    .i_flush_evt    (redirect),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed-vector bench for fetch_controller with hand-computed expectations.
module tb_fetch_controller;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus_4;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_controller #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .pc_plus_4     (pc_plus_4),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] addr;

  initial begin
    // reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_req",   {31'd0, mem_req}, 32'd1);
    chk("rst_addr",  mem_addr, 32'h100);
    chk("rst_vld",   {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc",   instr_pc, 32'd0);
    chk("rst_stc",   stall_cycles, 32'd0);
    chk("rst_flc",   flush_count, 32'd0);

    // sequential fetch, ack one cycle after each request
    for (int k = 0; k < 3; k++) begin
      addr = 32'h100 + 32'(4 * k);
      chk("seq_addr0", mem_addr, addr);
      chk("seq_vld0",  {31'd0, instr_valid}, 32'd0);
      step();
      chk("seq_addr1", mem_addr, addr);
      chk("seq_req1",  {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1;
      mem_rdata = 32'hA000_0000 | 32'(k);
      step();
      mem_ack = 1'b0;
      chk("seq_vld",   {31'd0, instr_valid}, 32'd1);
      chk("seq_instr", instr, 32'hA000_0000 | 32'(k));
      chk("seq_ipc",   instr_pc, addr);
      chk("seq_pc4",   pc_plus_4, addr + 32'd4);
      chk("seq_noreq", {31'd0, mem_req}, 32'd0);
      step();
    end

    // redirect coincident with ack: data discarded
    chk("ra_pre", mem_addr, 32'h10C);
    redirect = 1'b1; redirect_addr = 32'h200;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    redirect = 1'b0; mem_ack = 1'b0;
    chk("ra_addr", mem_addr, 32'h200);
    chk("ra_vld",  {31'd0, instr_valid}, 32'd0);
    chk("ra_flc",  flush_count, PERF_ON ? 32'd1 : 32'd0);

    // ack for 0x200 while stall held for three HOLD cycles
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) stall = 1'b0;
      chk("st_vld",   {31'd0, instr_valid}, 32'd1);
      chk("st_instr", instr, 32'h1111_2222);
      chk("st_ipc",   instr_pc, 32'h200);
      chk("st_noreq", {31'd0, mem_req}, 32'd0);
      step();
    end
    chk("st_cnt", stall_cycles, PERF_ON ? 32'd3 : 32'd0);
    chk("st_vld_off", {31'd0, instr_valid}, 32'd0);

    // redirect with request outstanding, ack two cycles later
    chk("dr_pre", mem_addr, 32'h204);
    redirect = 1'b1; redirect_addr = 32'h400;
    step();
    redirect = 1'b0;
    chk("dr_hold0", mem_addr, 32'h204);
    chk("dr_req0",  {31'd0, mem_req}, 32'd1);
    chk("dr_vld0",  {31'd0, instr_valid}, 32'd0);
    step();
    chk("dr_hold1", mem_addr, 32'h204);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("dr_next", mem_addr, 32'h400);
    chk("dr_vld2", {31'd0, instr_valid}, 32'd0);
    chk("dr_flc",  flush_count, PERF_ON ? 32'd2 : 32'd0);

    // zero-wait fetch of 0x400
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    step();
    mem_ack = 1'b0;
    chk("zw_vld", {31'd0, instr_valid}, 32'd1);
    chk("zw_ipc", instr_pc, 32'h400);

    // redirect during stalled HOLD
    stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h800;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("hr_vld",  {31'd0, instr_valid}, 32'd0);
    chk("hr_req",  {31'd0, mem_req}, 32'd1);
    chk("hr_addr", mem_addr, 32'h800);
    chk("hr_flc",  flush_count, PERF_ON ? 32'd3 : 32'd0);

    // enter DROP, then reset mid-transaction
    redirect = 1'b1; redirect_addr = 32'hC00;
    step();
    redirect = 1'b0;
    chk("rd_drop", mem_addr, 32'h800);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_req",  {31'd0, mem_req}, 32'd1);
    chk("rd_vld",  {31'd0, instr_valid}, 32'd0);
    chk("rd_stc",  stall_cycles, 32'd0);
    chk("rd_flc",  flush_count, 32'd0);

    // back-to-back redirects in DROP (last wins), then wrap past 0xFFFFFFFC
    redirect = 1'b1; redirect_addr = 32'h300;
    step();
    redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_drop", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    chk("wr_tgt", mem_addr, 32'hFFFF_FFFC);
    mem_rdata = 32'h6666_6666;
    step();
    mem_ack = 1'b0;
    chk("wr_ipc",   instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, 32'h6666_6666);
    chk("wr_pc4",   pc_plus_4, 32'h0);
    step();
    chk("wr_addr0", mem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch against a multi-cycle instruction memory with a req/ack handshake, replacing direct combinational memory reads in the fetch stage. Holds the fetch PC and one fetched instruction for decode, honours the hazard unit's stall, and flushes on jump/branch redirects, discarding any in-flight memory response. Sits between the PC-select muxes (redirect source), the hazard unit (stall), the instruction memory and the decode pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; decode does not accept instr while high
- redirect  in  1  taken jump / jump-register / branch this cycle
- redirect_addr  in  32  target address when redirect=1
- mem_req  out  1  instruction-memory request
- mem_addr  out  32  request address; stable while mem_req=1
- mem_ack  in  1  one-cycle response strobe; mem_rdata valid in same cycle
- mem_rdata  in  32  instruction word
- instr  out  32  held instruction for decode
- instr_valid  out  1  instr holds a live instruction
- instr_pc  out  32  address of instr
- pc_plus_4  out  32  instr_pc + 4 (combinational, wraps mod 2^32)
- stall_cycles  out  32  perf: cycles in HOLD with stall=1
- flush_count  out  32  perf: accepted redirects

## Operation
- States: FETCH, HOLD, DROP. Registers: fetch_pc, instr, instr_pc, instr_valid.
- FETCH: mem_req=1, mem_addr=fetch_pc. On mem_ack (no redirect): instr<=mem_rdata, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4, -> HOLD.
- HOLD: mem_req=0, instr_valid=1. stall=1: stay. stall=0: instruction consumed this cycle; instr_valid<=0, -> FETCH.
- DROP: mem_req=1 with the abandoned address held; on mem_ack discard mem_rdata, -> FETCH.
- redirect (any state) has priority over stall and ack: fetch_pc<=redirect_addr, instr_valid<=0; FETCH without ack -> DROP; FETCH with ack same cycle -> FETCH (data discarded); HOLD -> FETCH; DROP stays DROP (target overwritten, last one wins).
- mem_req never deasserts before mem_ack once raised; mem_addr never changes while outstanding.
- Address arithmetic 32-bit, wrap at 32'hFFFF_FFFC -> 0; no alignment checks.

## Timing
- Reset values: state=FETCH, fetch_pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, counters=0; mem_req=1 in first cycle after reset deasserts.
- Latency: ack in cycle N -> instr_valid=1 in N+1. Zero-wait memory (ack in request cycle) gives one instruction per 2 cycles.
- redirect in cycle N -> instr_valid=0 in N+1; new address on mem_addr in N+1 unless in DROP.
- Reset asserted mid-transaction abandons it; memory must be reset in the same cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: stall_cycles and flush_count increment as above, wrap at 2^32, cleared by reset.
- Undefined: counters not built; both outputs tied to 0.

## Structure
- Package fetch_ctrl_pkg: state enum (FETCH, HOLD, DROP), PC_INCR=32'd4, default RESET_PC.
- One sub-module: fetch_perf_cnt (the two counters), instantiated only under FETCH_PERF_CNT_EN.

## Test plan
- Reset, RESET_PC=0x100, ack 1 cycle after each req, stall=0 -> mem_addr 0x100, 0x104, 0x108; instr_pc matches; one instr_valid pulse per fetch.
- Ack for 0x200 while stall held 3 cycles -> instr/instr_pc stable for 4 cycles, stall_cycles=3 (macro on), 0 (macro off).
- redirect to 0x400 while req to 0x204 outstanding, ack 2 cycles later -> mem_addr stays 0x204 until ack, data dropped, next mem_addr 0x400, no instr_valid for 0x204.
- redirect and mem_ack same cycle -> data discarded, next mem_addr=redirect_addr, flush_count+1.
- redirect with stall=1 in HOLD -> instr_valid=0 next cycle, fetch resumes at target.
- reset asserted while in DROP -> next cycle mem_addr=RESET_PC, instr_valid=0, counters 0.
